// File: rtl/adc_cmd_spi_master.sv
// SPI master for the ADC128S022: one 16-SCLK conversion frame per rising edge of cmd[3].
// Define ADC_AVG_EN to run four frames per trigger and report their truncating mean.
module adc_cmd_spi_master #(
  parameter int CLK_DIV = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  cmd,
  output logic [11:0] result,
  output logic [2:0]  result_chan,
  output logic        busy,
  output logic        done,
  output logic        adc_cs_n,
  output logic        adc_sclk,
  output logic        adc_din,
  input  logic        adc_dout
);

  localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [DIV_W-1:0] DIV_ZERO = DIV_W'(0);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CS_SETUP = 3'd1,
    S_SHIFT    = 3'd2,
    S_CS_HOLD  = 3'd3,
    S_FINISH   = 3'd4,
    S_GAP      = 3'd5
  } state_t;

  // Control bits of the ADC command: channel address sits in bits 2..4 of the frame.
  function automatic logic din_for(input logic [3:0] bit_idx, input logic [2:0] chan);
    logic v;
    case (bit_idx)
      4'd2:    v = chan[2];
      4'd3:    v = chan[1];
      4'd4:    v = chan[0];
      default: v = 1'b0;
    endcase
    return v;
  endfunction

  state_t            r_state, w_state_nxt;
  logic [DIV_W-1:0]  r_div, w_div_nxt;
  logic [3:0]        r_bit, w_bit_nxt;
  logic              r_phase, w_phase_nxt;   // 0 = SCLK low half, 1 = SCLK high half
  logic [2:0]        r_chan, w_chan_nxt;
  logic [11:0]       r_shreg, w_shreg_nxt;
  logic [11:0]       r_result, w_result_nxt;
  logic [2:0]        r_result_chan, w_rchan_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_done, w_done_nxt;
  logic              r_cs_n, w_cs_n_nxt;
  logic              r_sclk, w_sclk_nxt;
  logic              r_din, w_din_nxt;
  logic              r_start_d;
  logic              w_trig;
  logic              w_div_last;
`ifdef ADC_AVG_EN
  logic [13:0]       r_acc, w_acc_nxt, w_acc_sum;
  logic [1:0]        r_frame, w_frame_nxt;
`endif

  assign w_trig     = cmd[3] & ~r_start_d;
  assign w_div_last = (r_div == DIV_LAST);

  // Next-state and next-output logic; every register holds unless a branch changes it.
  always_comb begin
    w_state_nxt  = r_state;
    w_div_nxt    = r_div;
    w_bit_nxt    = r_bit;
    w_phase_nxt  = r_phase;
    w_chan_nxt   = r_chan;
    w_shreg_nxt  = r_shreg;
    w_result_nxt = r_result;
    w_rchan_nxt  = r_result_chan;
    w_busy_nxt   = r_busy;
    w_done_nxt   = r_done;
    w_cs_n_nxt   = r_cs_n;
    w_sclk_nxt   = r_sclk;
    w_din_nxt    = r_din;
`ifdef ADC_AVG_EN
    w_acc_nxt    = r_acc;
    w_frame_nxt  = r_frame;
    w_acc_sum    = r_acc + {2'b00, r_shreg};
`endif
    case (r_state)
      S_IDLE: begin
        if (w_trig) begin
          w_chan_nxt  = cmd[2:0];
          w_state_nxt = S_CS_SETUP;
          w_div_nxt   = DIV_ZERO;
          w_busy_nxt  = 1'b1;
          w_done_nxt  = 1'b0;
          w_cs_n_nxt  = 1'b0;
          w_sclk_nxt  = 1'b1;
          w_din_nxt   = 1'b0;
`ifdef ADC_AVG_EN
          w_acc_nxt   = 14'd0;
          w_frame_nxt = 2'd0;
`endif
        end else begin
          w_div_nxt   = DIV_ZERO;
        end
      end
      S_CS_SETUP: begin
        if (w_div_last) begin
          w_state_nxt = S_SHIFT;
          w_div_nxt   = DIV_ZERO;
          w_bit_nxt   = 4'd0;
          w_phase_nxt = 1'b0;
          w_sclk_nxt  = 1'b0;
          w_din_nxt   = din_for(4'd0, r_chan);
        end else begin
          w_div_nxt   = r_div + DIV_ONE;
        end
      end
      S_SHIFT: begin
        if (!w_div_last) begin
          w_div_nxt = r_div + DIV_ONE;
        end else if (!r_phase) begin
          // Rising SCLK edge: the ADC drove DOUT on the previous falling edge.
          w_div_nxt   = DIV_ZERO;
          w_phase_nxt = 1'b1;
          w_sclk_nxt  = 1'b1;
          if (r_bit >= 4'd4) begin
            w_shreg_nxt = {r_shreg[10:0], adc_dout};
          end else begin
            w_shreg_nxt = r_shreg;
          end
        end else if (r_bit == 4'd15) begin
          w_div_nxt   = DIV_ZERO;
          w_state_nxt = S_CS_HOLD;
          w_din_nxt   = 1'b0;
        end else begin
          w_div_nxt   = DIV_ZERO;
          w_bit_nxt   = r_bit + 4'd1;
          w_phase_nxt = 1'b0;
          w_sclk_nxt  = 1'b0;
          w_din_nxt   = din_for(r_bit + 4'd1, r_chan);
        end
      end
      S_CS_HOLD: begin
        if (w_div_last) begin
          w_div_nxt  = DIV_ZERO;
          w_cs_n_nxt = 1'b1;
`ifdef ADC_AVG_EN
          w_acc_nxt  = w_acc_sum;
          if (r_frame == 2'd3) begin
            w_state_nxt  = S_FINISH;
            w_busy_nxt   = 1'b0;
            w_done_nxt   = 1'b1;
            w_result_nxt = w_acc_sum[13:2];
            w_rchan_nxt  = r_chan;
          end else begin
            w_state_nxt  = S_GAP;
            w_frame_nxt  = r_frame + 2'd1;
          end
`else
          w_state_nxt  = S_FINISH;
          w_busy_nxt   = 1'b0;
          w_done_nxt   = 1'b1;
          w_result_nxt = r_shreg;
          w_rchan_nxt  = r_chan;
`endif
        end else begin
          w_div_nxt  = r_div + DIV_ONE;
        end
      end
      S_FINISH: begin
        w_state_nxt = S_IDLE;
      end
      S_GAP: begin
`ifdef ADC_AVG_EN
        if (w_div_last) begin
          w_div_nxt   = DIV_ZERO;
          w_state_nxt = S_CS_SETUP;
          w_cs_n_nxt  = 1'b0;
        end else begin
          w_div_nxt   = r_div + DIV_ONE;
        end
`else
        w_state_nxt = S_IDLE;
`endif
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath, counters and registered pin/status outputs; start_d resets high so a held start cannot fire.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_div         <= DIV_ZERO;
      r_bit         <= 4'd0;
      r_phase       <= 1'b0;
      r_chan        <= 3'd0;
      r_shreg       <= 12'd0;
      r_result      <= 12'd0;
      r_result_chan <= 3'd0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_cs_n        <= 1'b1;
      r_sclk        <= 1'b1;
      r_din         <= 1'b0;
      r_start_d     <= 1'b1;
`ifdef ADC_AVG_EN
      r_acc         <= 14'd0;
      r_frame       <= 2'd0;
`endif
    end else begin
      r_div         <= w_div_nxt;
      r_bit         <= w_bit_nxt;
      r_phase       <= w_phase_nxt;
      r_chan        <= w_chan_nxt;
      r_shreg       <= w_shreg_nxt;
      r_result      <= w_result_nxt;
      r_result_chan <= w_rchan_nxt;
      r_busy        <= w_busy_nxt;
      r_done        <= w_done_nxt;
      r_cs_n        <= w_cs_n_nxt;
      r_sclk        <= w_sclk_nxt;
      r_din         <= w_din_nxt;
      r_start_d     <= cmd[3];
`ifdef ADC_AVG_EN
      r_acc         <= w_acc_nxt;
      r_frame       <= w_frame_nxt;
`endif
    end
  end

  assign result      = r_result;
  assign result_chan = r_result_chan;
  assign busy        = r_busy;
  assign done        = r_done;
  assign adc_cs_n    = r_cs_n;
  assign adc_sclk    = r_sclk;
  assign adc_din     = r_din;

endmodule

// File: tb/tb_adc_cmd_spi_master.sv
// Self-checking bench for adc_cmd_spi_master: timeline model of busy/done/result plus an ADC128S022 model.
module tb_adc_cmd_spi_master;

  localparam int CD = 2;
`ifdef ADC_AVG_EN
  localparam int NF = 4;
  localparam int EXP_BUSY_LEN = 278;
`else
  localparam int NF = 1;
  localparam int EXP_BUSY_LEN = 68;
`endif
  localparam int L = NF * 34 * CD + (NF - 1) * CD;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  cmd = 4'b1000;
  logic [11:0] result;
  logic [2:0]  result_chan;
  logic        busy, done, adc_cs_n, adc_sclk, adc_din;
  logic        adc_dout = 1'b0;

  logic [11:0] adc_vals [4];
  int n_checks = 0;
  int n_pass = 0;

  adc_cmd_spi_master #(.CLK_DIV(CD)) dut (
    .clk(clk), .reset_n(reset_n), .cmd(cmd),
    .result(result), .result_chan(result_chan), .busy(busy), .done(done),
    .adc_cs_n(adc_cs_n), .adc_sclk(adc_sclk), .adc_din(adc_din), .adc_dout(adc_dout)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [11:0] mean_val();
    int s = 0;
    for (int i = 0; i < NF; i++) s += int'(adc_vals[i]);
    return 12'(s / NF);
  endfunction

  // Timeline model: a trigger seen at edge T makes busy span T+1..T+L and completion land at T+1+L.
  int m_cyc = 0, m_fin = -100, m_prev = 0;
  bit m_active = 1'b0, m_start_d = 1'b1, m_done = 1'b0, m_idle, m_tr;
  logic [11:0] m_result = 12'd0, m_pend_res = 12'd0;
  logic [2:0]  m_chan = 3'd0, m_pend_chan = 3'd0;

  initial forever begin
    @(posedge clk or negedge reset_n);
    if (!reset_n) begin
      m_start_d = 1'b1; m_active = 1'b0; m_fin = -100;
      m_done = 1'b0; m_result = 12'd0; m_chan = 3'd0;
    end else begin
      m_prev = m_cyc;
      m_cyc++;
      m_idle = !m_active && (m_prev != m_fin);
      m_tr = cmd[3] && !m_start_d;
      m_start_d = cmd[3];
      if (m_active && m_cyc == m_fin) begin
        m_active = 1'b0; m_done = 1'b1; m_result = m_pend_res; m_chan = m_pend_chan;
      end
      if (m_tr && m_idle) begin
        m_active = 1'b1; m_fin = m_cyc + L; m_done = 1'b0;
        m_pend_chan = cmd[2:0]; m_pend_res = mean_val();
      end
    end
  end

  // Per-cycle comparison against the model.
  initial forever begin
    @(negedge clk);
    chk("busy", 32'(busy), 32'(m_active));
    chk("done", 32'(done), 32'(m_done));
    chk("result", 32'(result), 32'(m_result));
    chk("result_chan", 32'(result_chan), 32'(m_chan));
    if (!m_active) begin
      chk("idle_cs_n", 32'(adc_cs_n), 32'd1);
      chk("idle_sclk", 32'(adc_sclk), 32'd1);
      chk("idle_din", 32'(adc_din), 32'd0);
    end
  end

  // Cycle-level bus statistics.
  int busy_run = 0, last_busy_len = 0, setup_cnt = 0, last_setup = 0, cs_falls = 0, gap_rises = 0;
  logic prev_cs = 1'b1, prev_busy = 1'b0;
  int fall_cnt = 0;

  initial forever begin
    @(negedge clk);
    if (busy && !prev_busy) busy_run = 0;
    if (busy) busy_run++;
    if (!busy && prev_busy) last_busy_len = busy_run;
    if (!adc_cs_n && prev_cs) cs_falls++;
    if (adc_cs_n && !prev_cs && busy) gap_rises++;
    if (adc_cs_n) setup_cnt = 0;
    else if (fall_cnt == 0) begin setup_cnt++; last_setup = setup_cnt; end
    prev_cs = adc_cs_n;
    prev_busy = busy;
  end

  // ADC model: four leading zeros then D11..D0, each driven on an SCLK falling edge.
  int din_hi_chg = 0, fidx = 0;
  logic [15:0] din_vec = 16'd0;
  logic [11:0] cur_val = 12'd0;
  logic pb_cs = 1'b1, pb_sclk = 1'b1, pb_din = 1'b0;

  initial forever begin
    @(adc_cs_n or adc_sclk or busy or adc_din);
    if (!busy) fidx = 0;
    if (adc_cs_n) begin
      adc_dout = 1'b0;
    end else if (pb_cs) begin
      cur_val = adc_vals[fidx % 4];
      fidx++;
      fall_cnt = 0;
      din_vec = 16'd0;
      adc_dout = 1'b0;
    end else begin
      if (!adc_sclk && pb_sclk) begin
        adc_dout = (fall_cnt >= 4) ? cur_val[15 - fall_cnt] : 1'b0;
        fall_cnt++;
      end
      if (adc_sclk && !pb_sclk && fall_cnt >= 1 && fall_cnt <= 16) din_vec[fall_cnt - 1] = adc_din;
      if (adc_din != pb_din && adc_sclk) din_hi_chg++;
    end
    pb_cs = adc_cs_n; pb_sclk = adc_sclk; pb_din = adc_din;
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
  endtask

  task automatic fire(input logic [2:0] ch);
    cmd = {1'b0, ch}; step(1);
    cmd = {1'b1, ch}; step(1);
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < L + 50; i++) begin
      @(negedge clk);
      if (done === 1'b1) break;
    end
    chk(name, 32'(done), 32'd1);
  endtask

  task automatic set_vals(input logic [11:0] a, input logic [11:0] b, input logic [11:0] c, input logic [11:0] d);
    adc_vals[0] = a; adc_vals[1] = b; adc_vals[2] = c; adc_vals[3] = d;
  endtask

  typedef struct { logic [11:0] val; logic [2:0] ch; } vec_t;
  vec_t vecs [3];
  int c0;

  initial begin
    set_vals(12'h000, 12'h000, 12'h000, 12'h000);
    // Start held high through reset must not trigger.
    step(3);
    reset_n = 1'b1;
    step(40);
    chk("hold_busy", 32'(busy), 32'd0);
    chk("hold_cs_falls", 32'(cs_falls), 32'd0);
    chk("hold_cs_n", 32'(adc_cs_n), 32'd1);

    // Basic frame: channel 5, ADC returns A5C.
    set_vals(12'hA5C, 12'hA5C, 12'hA5C, 12'hA5C);
    fire(3'd5);
    wait_done("done_timeout_a5c");
    chk("a5c_result", 32'(result), 32'h0A5C);
    chk("a5c_chan", 32'(result_chan), 32'd5);
    chk("a5c_done", 32'(done), 32'd1);
    chk("a5c_busy_len", 32'(last_busy_len), 32'(EXP_BUSY_LEN));
    chk("din_bits", 32'(din_vec), 32'h0014);
    chk("sclk_falls", 32'(fall_cnt), 32'd16);
    chk("cs_setup", 32'(last_setup), 32'(CD));
    chk("din_stable", 32'(din_hi_chg), 32'd0);

    // Second rising start while busy is dropped; then one lands on the FINISH cycle.
    set_vals(12'h3C1, 12'h3C1, 12'h3C1, 12'h3C1);
    c0 = cs_falls;
    fire(3'd5);
    step(5);
    cmd = 4'b0000; step(1);
    cmd = 4'b1010; step(1);
    cmd = 4'b0000;
    wait_done("done_timeout_3c1");
    cmd = 4'b1110;
    step(10);
    chk("busy_ignored_cs", 32'(cs_falls - c0), 32'(NF));
    chk("busy_ignored_chan", 32'(result_chan), 32'd5);
    chk("busy_ignored_result", 32'(result), 32'h03C1);
    chk("finish_trig_dropped", 32'(busy), 32'd0);
    chk("finish_trig_done", 32'(done), 32'd1);

    // Reset during bit 9 of a frame returning FFF.
    set_vals(12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF);
    cmd = 4'b0000; step(1);
    fire(3'd1);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (fall_cnt >= 10) break;
    end
    chk("reach_bit9", 32'(fall_cnt >= 10), 32'd1);
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_chan", 32'(result_chan), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_cs_n", 32'(adc_cs_n), 32'd1);
    chk("rst_sclk", 32'(adc_sclk), 32'd1);
    chk("rst_din", 32'(adc_din), 32'd0);
    step(2);
    reset_n = 1'b1;
    set_vals(12'h5A3, 12'h5A3, 12'h5A3, 12'h5A3);
    cmd = 4'b0000; step(1);
    fire(3'd6);
    wait_done("done_timeout_5a3");
    chk("after_rst_result", 32'(result), 32'h05A3);
    chk("after_rst_chan", 32'(result_chan), 32'd6);

`ifdef ADC_AVG_EN
    // Averaging: (100+101+102+104)/4 = 407/4 -> 101.
    set_vals(12'd100, 12'd101, 12'd102, 12'd104);
    c0 = gap_rises;
    fire(3'd2);
    wait_done("done_timeout_avg");
    chk("avg_result", 32'(result), 32'd101);
    chk("avg_gaps", 32'(gap_rises - c0), 32'd3);
    chk("avg_busy_len", 32'(last_busy_len), 32'd278);
`else
    // Data and channel boundaries.
    vecs[0] = '{val: 12'h001, ch: 3'd7};
    vecs[1] = '{val: 12'h800, ch: 3'd0};
    vecs[2] = '{val: 12'hFFF, ch: 3'd3};
    for (int k = 0; k < 3; k++) begin
      set_vals(vecs[k].val, vecs[k].val, vecs[k].val, vecs[k].val);
      fire(vecs[k].ch);
      wait_done("done_timeout_vec");
      chk("vec_result", 32'(result), 32'(vecs[k].val));
      chk("vec_chan", 32'(result_chan), 32'(vecs[k].ch));
      cmd = 4'b0000; step(2);
    end
`endif

    step(5);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/adc_cmd_spi_master.md
Name: adc_cmd_spi_master

Overview:
- Executes the 4-bit ADC command word written by the NIOS II to the adc_cmd output PIO.
- On a start request, runs one 16-SCLK SPI frame to the DE0-Nano ADC128S022 on the channel selected by the command.
- Returns the 12-bit conversion plus busy/done status, which an input PIO reads back.
- Sits in the clk domain between the PIO and the ADC pins.

Parameters:
- CLK_DIV, 16, clk cycles per SCLK half-period. Legal range is 2 or more. At 50 MHz the default gives SCLK = 1.5625 MHz.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- cmd  in  4  from the adc_cmd PIO. cmd[3] = start, cmd[2:0] = channel.
- result  out  12  last completed conversion
- result_chan  out  3  channel that produced result
- busy  out  1  frame (or frame group) in progress
- done  out  1  sticky completion flag
- adc_cs_n  out  1  ADC chip select
- adc_sclk  out  1  ADC serial clock, idles high
- adc_din  out  1  ADC control input
- adc_dout  in  1  ADC data output

Behaviour:
- Reset values:
  - adc_cs_n=1, adc_sclk=1, adc_din=0
  - result=0, result_chan=0, busy=0, done=0
  - start_d=1, so start held high through reset cannot trigger
  - state=IDLE
- Trigger:
  - start_d <= cmd[3] every cycle. trig = cmd[3] & ~start_d.
  - trig is honoured only in IDLE. A trig in any other state is dropped; no queueing.
- On honoured trig at cycle T:
  - cmd[2:0] is captured into chan_q.
  - At T+1: busy=1, done=0, adc_cs_n=0, state=CS_SETUP.
- States and transitions:
  - IDLE: waits for trig.
  - CS_SETUP: adc_sclk=1 for CLK_DIV cycles, then SHIFT with bit=0.
  - SHIFT: 16 bit periods, bit=0..15.
    - Each period is CLK_DIV cycles with adc_sclk=0, then CLK_DIV cycles with adc_sclk=1.
    - adc_din updates on entry to the low phase: chan_q[2] for bit 2, chan_q[1] for bit 3, chan_q[0] for bit 4, else 0.
    - On the clk cycle where adc_sclk goes 0→1, adc_dout is sampled. For bit 4..15 it shifts MSB-first into shreg[11:0]. bit 0..3 samples are discarded.
    - After bit 15's high phase, go to CS_HOLD.
  - CS_HOLD: adc_sclk=1, adc_din=0, adc_cs_n=0 for CLK_DIV cycles, then FINISH.
  - FINISH, one cycle:
    - adc_cs_n=1, busy=0, done=1
    - result<=shreg, result_chan<=chan_q
    - next state IDLE
- Latency:
  - busy high from T+1 through T+34*CLK_DIV inclusive.
  - busy falls and done rises at T+1+34*CLK_DIV.
  - result is stable thereafter until the next completion.
- done stays high until the next honoured trig clears it at T+1.
- A trig coincident with FINISH is dropped, since state is not yet IDLE.
- Reset mid-frame: all outputs return to reset values immediately (asynchronous). A partial shreg is never transferred to result.
- Division: one 0..CLK_DIV-1 counter plus one 0..15 bit counter. Counters wrap to 0 at each phase/state change.

Optional Feature:
- Macro: ADC_AVG_EN.
- Defined:
  - Each honoured trig runs 4 complete frames back to back. adc_cs_n goes high for exactly CLK_DIV cycles between frames.
  - Each frame's 12-bit value is added into a 14-bit accumulator, cleared at trig.
  - At the final FINISH, result<=acc[13:2] (truncating mean).
  - busy covers all 4 frames, and done rises only after the 4th.
- Undefined: a single frame per trig, as above. No accumulator is present.

Test Plan:
- Reset with cmd=4'b1000 held, release, hold cmd → no trig, busy=0, adc_cs_n=1 indefinitely.
- CLK_DIV=2, cmd 0→4'b1101 (chan 5), ADC model returns 12'hA5C → busy 1 for 68 cycles. DIN bits 2..4 = 1,0,1. result=12'hA5C, result_chan=5, done=1.
- Second 0→1 on cmd[3] while busy (chan 2) → ignored. adc_cs_n toggles once. result_chan stays 5.
- Check SCLK/CS timing: 16 falling edges per frame. DIN stable across each rising edge. CS low CLK_DIV cycles before the first falling edge.
- Assert reset_n=0 at bit 9 of a frame returning 12'hFFF → outputs at reset values. The next trig returns a fresh correct result; the 12'hFFF never appears.
- ADC_AVG_EN defined, model returns 100, 101, 102, 104 → result=101 (407>>2). busy spans 4 frames. adc_cs_n high 3 times between frames.
